uart_tx_word_feeder: RTL and testbench

//  Upstream stage of the UART transmitter: buffers 32-bit words from the core in a FIFO.

---
 rtl/uart_tx_word_feeder_if.sv | 20 ++
 rtl/uart_tx_word_feeder.sv | 117 +++++++++++
 tb/tb_uart_tx_word_feeder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_word_feeder_if.sv
// Handshake bundle between the core-side word source, the word feeder and the UART TX byte engine.
// The master side is the environment (core + engine); the slave side is the feeder itself.
interface uart_tx_word_feeder_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  sdata;

  modport master (
    output in_valid, in_data, tx_busy,
    input  in_ready, tx_start, sdata
  );

  modport slave (
    input  in_valid, in_data, tx_busy,
    output in_ready, tx_start, sdata
  );
endinterface

// File: rtl/uart_tx_word_feeder.sv
// Word FIFO in front of the UART TX byte engine: splits each 32-bit word into 4 bytes,
// LSB first, and paces them on the engine's tx_busy.
//
// state | meaning
// IDLE  | no word in flight; pops the FIFO head when one is stored
// START | tx_start high for this single cycle, sdata already valid
// HOLD  | guard cycle that gives the engine time to raise tx_busy
// WAIT  | byte on the wire; leaves when tx_busy drops
module uart_tx_word_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  uart_tx_word_feeder_if.slave bus,
  output logic [ADDR_W:0]     fifo_count,
  output logic                idle
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_HOLD, S_WAIT} state_t;

  localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  state_t          state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [31:0]     sh_q, sh_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic            tx_start_q, tx_start_d;
  logic [31:0]     mem_q [DEPTH];

  logic        in_ready;
  logic        push;
  logic        pop;
  logic [31:0] head;

  // in_ready looks only at the registered count, so a pop never frees a slot in the same cycle
  assign in_ready = (count_q != DEPTH_CNT);
  assign push     = bus.in_valid && in_ready;
  assign pop      = (state_q == S_IDLE) && (count_q != '0);
  assign head     = mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    sh_d       = sh_q;
    byte_idx_d = byte_idx_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (push && !pop)      count_d = count_q + PTR_ONE;
    else if (pop && !push) count_d = count_q - PTR_ONE;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          sh_d       = head;
          byte_idx_d = 2'd0;
          state_d    = S_START;
        end
      end
      S_START: state_d = S_HOLD;
      S_HOLD:  state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.tx_busy) begin
          if (byte_idx_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            sh_d       = {8'h00, sh_q[31:8]};
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    tx_start_d = (state_d == S_START);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sh_q       <= '0;
      byte_idx_q <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sh_q       <= sh_d;
      byte_idx_q <= byte_idx_d;
      tx_start_q <= tx_start_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.in_data;
  end

  // sh[7:0] only changes on the edge entering START, so it doubles as the held sdata register
  assign bus.sdata    = sh_q[7:0];
  assign bus.tx_start = tx_start_q;
  assign bus.in_ready = in_ready;
  assign fifo_count   = count_q;
  assign idle         = (state_q == S_IDLE) && (count_q == '0);

endmodule

// File: tb/tb_uart_tx_word_feeder.sv
// Bench for uart_tx_word_feeder: queue-based reference model checked every cycle,
// a reactive UART engine stand-in, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_uart_tx_word_feeder;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [ADDR_W:0] fifo_count;
  logic            idle;

  uart_tx_word_feeder_if bus_if();

  uart_tx_word_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus_if),
    .fifo_count (fifo_count),
    .idle       (idle)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, one word in flight as a byte countdown.
  logic [31:0] m_q[$];
  bit          m_inflight = 0;
  int          m_left = 0;
  int          m_guard = 0;
  logic [31:0] m_cur = 0;
  logic [7:0]  m_sdata = 0;
  bit          m_start = 0;
  int          m_cnt;
  bit          m_acc;
  int          acc_cnt = 0;
  int          cyc = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_inflight = 0;
      m_left = 0;
      m_guard = 0;
      m_cur = 0;
      m_sdata = 0;
      m_start = 0;
    end else begin
      cyc++;
      m_cnt = m_q.size();
      m_acc = bus_if.in_valid && (m_cnt != DEPTH);
      m_start = 0;
      if (!m_inflight) begin
        if (m_cnt != 0) begin
          m_cur = m_q.pop_front();
          m_inflight = 1;
          m_left = 3;
          m_sdata = m_cur[7:0];
          m_start = 1;
          m_guard = 2;
        end
      end else if (m_guard > 0) begin
        m_guard--;
      end else if (!bus_if.tx_busy) begin
        if (m_left == 0) begin
          m_inflight = 0;
        end else begin
          m_cur = m_cur >> 8;
          m_sdata = m_cur[7:0];
          m_left--;
          m_start = 1;
          m_guard = 2;
        end
      end
      if (m_acc) begin
        m_q.push_back(bus_if.in_data);
        acc_cnt++;
      end
    end
  end

  // UART engine stand-in: busy for a set number of cycles after each tx_start.
  int busy_len = 20;
  bit eng_hold = 0;
  bit eng_rand = 0;
  int rem = 0;

  always @(negedge clock or posedge reset) begin
    if (reset) begin
      rem = 0;
      bus_if.tx_busy = 1'b0;
    end else begin
      if (rem > 0) rem--;
      if (bus_if.tx_start === 1'b1) rem = eng_rand ? int'($urandom_range(30, 1)) : busy_len;
      bus_if.tx_busy = (rem > 0) || eng_hold;
    end
  end

  logic [7:0] dut_bytes[$];
  int         start_cyc[$];

  always @(negedge clock) begin
    if (!reset) begin
      chk("tx_start",   32'(bus_if.tx_start), 32'(m_start));
      chk("sdata",      32'(bus_if.sdata),    32'(m_sdata));
      chk("fifo_count", 32'(fifo_count),      m_q.size());
      chk("in_ready",   32'(bus_if.in_ready), 32'(m_q.size() != DEPTH));
      chk("idle",       32'(idle),            32'(!m_inflight && m_q.size() == 0));
      if (bus_if.tx_start === 1'b1) begin
        dut_bytes.push_back(bus_if.sdata);
        start_cyc.push_back(cyc);
      end
    end
  end

  task automatic push_word(input logic [31:0] w, input int bound, output bit ok);
    int n0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = w;
    n0 = acc_cnt;
    ok = 0;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clock);
      ok = (acc_cnt != n0);
    end
    if (ok) bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    bit done;
    done = 0;
    for (int k = 0; k < bound && !done; k++) begin
      @(negedge clock);
      done = !m_inflight && (m_q.size() == 0);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=busy required=drained at %0t", $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_start"},   32'(bus_if.tx_start), 0);
    chk({tag, "_sdata"},      32'(bus_if.sdata),    0);
    chk({tag, "_fifo_count"}, 32'(fifo_count),      0);
    chk({tag, "_in_ready"},   32'(bus_if.in_ready), 1);
    chk({tag, "_idle"},       32'(idle),            1);
  endtask

  logic [7:0]  exp1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int          gap4 [7] = '{3, 3, 3, 4, 3, 3, 3};
  logic [31:0] words6[$];
  logic [7:0]  flat6[$];

  initial begin
    bit ok;
    int nacc;
    int n;
    int nbad;
    logic [31:0] w;

    bus_if.in_valid = 1'b0;
    bus_if.in_data  = '0;
    repeat (3) @(negedge clock);
    check_reset_outputs("por");
    reset = 1'b0;

    // 1: single word, 20-cycle bytes
    busy_len = 20;
    dut_bytes.delete();
    start_cyc.delete();
    push_word(32'h44332211, 10, ok);
    chk("t1_accept", 32'(ok), 1);
    wait_drain(2000);
    chk("t1_nbytes", dut_bytes.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < dut_bytes.size()) chk("t1_byte", 32'(dut_bytes[i]), 32'(exp1[i]));
    for (int i = 0; i < 3; i++)
      if (i + 1 < start_cyc.size()) chk("t1_gap", start_cyc[i+1] - start_cyc[i], 21);
    chk("t1_idle", 32'(idle), 1);

    // 2: engine stuck busy after first byte, offer 20 words
    eng_hold = 1;
    nacc = 0;
    for (int i = 0; i < 20; i++) begin
      push_word(32'hA000_0000 + i, 8, ok);
      if (!ok) break;
      nacc++;
    end
    chk("t2_accepted", nacc, 17);
    chk("t2_count", 32'(fifo_count), 16);
    chk("t2_in_ready", 32'(bus_if.in_ready), 0);

    // 3: release engine with the 18th word still offered
    eng_hold = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      if (fifo_count != 5'd16) break;
    end
    chk("t3_count_after_pop", 32'(fifo_count), 15);
    chk("t3_in_ready", 32'(bus_if.in_ready), 1);
    @(negedge clock);
    chk("t3_count_refill", 32'(fifo_count), 16);
    bus_if.in_valid = 1'b0;
    busy_len = 2;
    wait_drain(6000);

    // 4: engine never busy, two words
    busy_len = 0;
    dut_bytes.delete();
    start_cyc.delete();
    push_word(32'h0403_0201, 10, ok);
    push_word(32'h0807_0605, 10, ok);
    wait_drain(500);
    chk("t4_nbytes", start_cyc.size(), 8);
    for (int i = 0; i < 7; i++)
      if (i + 1 < start_cyc.size()) chk("t4_gap", start_cyc[i+1] - start_cyc[i], gap4[i]);
    for (int i = 0; i < 8; i++)
      if (i < dut_bytes.size()) chk("t4_byte", 32'(dut_bytes[i]), i + 1);

    // 5: reset while a byte is in WAIT and 3 words queued
    busy_len = 20;
    for (int i = 0; i < 4; i++) push_word(32'hC0DE_0000 + i, 10, ok);
    repeat (6) @(negedge clock);
    chk("t5_pre_count", 32'(fifo_count), 3);
    #2 reset = 1'b1;
    #1 check_reset_outputs("t5");
    @(negedge clock);
    reset = 1'b0;
    n = start_cyc.size();
    repeat (30) @(negedge clock);
    chk("t5_no_start", start_cyc.size(), n);
    chk("t5_idle", 32'(idle), 1);

    // 6: 40 random words, random busy lengths
    eng_rand = 1;
    dut_bytes.delete();
    words6.delete();
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      push_word(w, 500, ok);
      if (ok) words6.push_back(w);
      else chk("t6_push_timeout", 32'(ok), 1);
    end
    bus_if.in_valid = 1'b0;
    wait_drain(10000);
    foreach (words6[i])
      for (int b = 0; b < 4; b++) flat6.push_back(words6[i][8*b +: 8]);
    chk("t6_len", dut_bytes.size(), 160);
    nbad = 0;
    foreach (flat6[i])
      if (i >= dut_bytes.size() || dut_bytes[i] !== flat6[i]) nbad++;
    chk("t6_stream_bad_bytes", nbad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
